store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Store-side counterpart of the load-path byte/half extender: it turns SB/SH/SW requests from the execute stage into word-wide writes on a data memory that has no byte enables. Sub-word stores use a read-modify-write sequence: read the word, insert the byte or half into the correct lane, write the word back. Word stores write directly. The block sits between the LSU store port and the data RAM, which has a synchronous read.

## Interface
- `WORD_LENGTH`, default 32: data word width.
- `BYTE_LEN`, default 8: byte width.
- `ADDR_WIDTH`, default 32: byte-address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_data`  in  WORD_LENGTH  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- `mem_rd_en`  out  1  read strobe; data is returned on `mem_rdata` in the cycle after.
- `mem_rdata`  in  WORD_LENGTH  read data.
- `mem_we`  out  1  write strobe; memory writes on the edge that ends this cycle.
- `mem_wdata`  out  WORD_LENGTH  write data.
- `done`  out  1  one-cycle pulse, coincident with `mem_we`.
- `err`  out  1  one-cycle pulse for a misaligned or illegal request.

## Operation
- **States:** IDLE, RD, WR.
- **Acceptance:** a request is accepted on an edge where `req_valid && req_ready`. Address, data and size are registered on that edge.
- **Accepted request, IDLE transitions:**
  - byte, or half with addr[0]=0 → RD.
  - word with addr[1:0]=00 → WR.
  - half with addr[0]=1, word with addr[1:0]≠00, or size 11 → stays IDLE, `err`=1 in the next cycle, no memory activity.
- **RD:** `mem_rd_en`=1, `mem_addr` = registered word address. Then → WR.
- **WR:** `mem_we`=1, `done`=1, `mem_addr` as in RD. Then → IDLE.
  - Sub-word: `mem_wdata` = `mem_rdata` with lane replaced.
  - Word: `mem_wdata` = registered data.
- **Lanes (little-endian):**
  - Byte at addr[1:0]=k replaces bits [8k+7:8k].
  - Half at addr[1]=h replaces bits [16h+15:16h].
  - All other bits pass through from `mem_rdata` unchanged.
- **Reset:** all outputs 0 except `req_ready`=1; state IDLE.
  - `mem_we` and `mem_rd_en` are gated with `!rst`, so no write happens on an edge where `rst` is high.
  - An RMW in progress is abandoned and memory is left unchanged.
- **`req_ready` and `req_valid`:**
  - `req_ready` is derived from state only.
  - `req_valid` in RD or WR is ignored, not queued.

## Timing
- **Word store:** accept at edge E0 → WR during cycle E0..E1 → memory written at E1; `req_ready` high again after E1. Throughput: one word store every 2 cycles.
- **Sub-word store:** accept at E0 → RD → WR during E1..E2 → written at E2; `req_ready` high after E2.
- **`err` timing:** `err` is high during E0..E1; `req_ready` stays high, so a new request may be accepted at E1.
- **`mem_wdata` in WR:** combinational from `mem_rdata` and the registered fields. No added register stage.
- **`mem_addr`, `mem_wdata` when idle:** 0 whenever neither strobe is active.

## Structure
- **Package `mem_pkg`:** size encoding enum (`SIZE_B`, `SIZE_H`, `SIZE_W`), FSM state enum, `BYTE_LEN`/`WORD_LENGTH` constants. The load-side extender imports the same size enum.
- **Sub-module `store_lane_merge`:** combinational; inputs old word, new data, addr[1:0], size; output merged word. It is the inverse of the load extender and is unit-tested separately.
- **Top level:** FSM, request registers, strobe gating.

## Test plan
- **SB lane replace:** memory word 0x11223344 at 0x100; SB addr 0x102 data 0xAB → one RD, then WR of 0x11AB3344, `done` pulse at E2.
- **SH upper half:** SH addr 0x102 data 0xBEEF on 0x11223344 → written 0xBEEF3344. SH addr 0x100 → 0x1122BEEF.
- **SW direct write:** SW addr 0x104 data 0xDEADBEEF → no `mem_rd_en`, WR at the cycle after accept, `req_ready` low for exactly 1 cycle.
- **Misaligned and illegal requests:** SH addr 0x101, SW addr 0x106, size 11 → `err` pulse 1 cycle after each, `mem_rd_en`/`mem_we` never asserted, back-to-back acceptance works.
- **Reset in WR:** `rst` asserted during the WR cycle of SB → `mem_we` low at that edge, memory still 0x11223344, outputs at reset values, next request behaves normally.
- **Back-to-back mixed stream:** SB, SW, SH with `req_valid` held high → each accepted only in IDLE, final memory contents match a reference model.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access encodings for the load extender and the store RMW unit.
package mem_pkg;

  localparam int BYTE_LEN    = 8;
  localparam int WORD_LENGTH = 32;

  // 2'b11 is deliberately left out: it is the illegal size code.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_e;

endpackage

// File: rtl/store_rmw_unit_if.sv
// Store request port and word-wide data RAM port seen by the store RMW unit.
interface store_rmw_unit_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
);

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [WORD_LENGTH-1:0] req_data;
  logic [1:0]             req_size;

  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;
  logic [WORD_LENGTH-1:0] mem_rdata;
  logic                   mem_we;
  logic [WORD_LENGTH-1:0] mem_wdata;

  logic                   done;
  logic                   err;

  // The unit serves store requests and drives the RAM.
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, mem_addr, mem_rd_en, mem_we, mem_wdata, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, mem_addr, mem_rd_en, mem_we, mem_wdata, done, err
  );

endinterface

// File: rtl/store_lane_merge.sv
// Inserts a right-aligned byte/half into the addressed little-endian lane of a word.
module store_lane_merge #(
  parameter int WORD_LENGTH = 32,
  parameter int BYTE_LEN    = 8
) (
  input  logic [WORD_LENGTH-1:0] old_word,
  input  logic [WORD_LENGTH-1:0] new_data,
  input  logic [1:0]             addr_lo,
  input  logic [1:0]             size,
  output logic [WORD_LENGTH-1:0] merged
);

  import mem_pkg::*;

  localparam int HALF_LEN = 2 * BYTE_LEN;

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_B:  merged[32'(addr_lo) * BYTE_LEN +: BYTE_LEN] = new_data[BYTE_LEN-1:0];
      SIZE_H:  merged[32'(addr_lo[1]) * HALF_LEN +: HALF_LEN] = new_data[HALF_LEN-1:0];
      SIZE_W:  merged = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// SB/SH/SW store sequencer for a data RAM without byte enables: sub-word
// stores read-modify-write the containing word, word stores write directly.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; misaligned/illegal ones only pulse err
//   RD      | read strobe on the word address, data returns next cycle
//   WR      | write strobe; sub-word data merged into mem_rdata, done pulse
module store_rmw_unit #(
  parameter int WORD_LENGTH = 32,
  parameter int BYTE_LEN    = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  store_rmw_unit_if.slave   bus
);

  import mem_pkg::*;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RD   = ST_RD;
  localparam logic [1:0] WR   = ST_WR;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic [1:0]             size_q;
  logic                   err_q;

  logic                   sub_ok;
  logic                   word_ok;
  logic                   rd_act;
  logic                   wr_act;
  logic [WORD_LENGTH-1:0] merged;

  assign sub_ok  = (bus.req_size == SIZE_B) ||
                   ((bus.req_size == SIZE_H) && !bus.req_addr[0]);
  assign word_ok = (bus.req_size == SIZE_W) && (bus.req_addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            size_q <= bus.req_size;
            if (sub_ok)       state <= RD;
            else if (word_ok) state <= WR;
            else              err_q <= 1'b1;
          end
        end
        RD:      state <= WR;
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  store_lane_merge #(
    .WORD_LENGTH (WORD_LENGTH),
    .BYTE_LEN    (BYTE_LEN)
  ) u_merge (
    .old_word (bus.mem_rdata),
    .new_data (data_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged)
  );

  // Strobes are gated with rst so an abandoned RMW never reaches the RAM.
  assign rd_act = (state == RD) && !rst;
  assign wr_act = (state == WR) && !rst;

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_rd_en = rd_act;
  assign bus.mem_we    = wr_act;
  assign bus.done      = wr_act;
  assign bus.err       = err_q && !rst;
  assign bus.mem_addr  = (rd_act || wr_act) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = wr_act ? merged : '0;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed lane/alignment/reset cases plus a random
// store stream compared against a byte-addressed reference memory.
module tb_store_rmw_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  store_rmw_unit_if bus ();

  store_rmw_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word RAM with synchronous read; 1 KiB window, preload port for setup.
  logic [31:0] mem_w [0:255];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)       mem_w[pl_addr[9:2]] <= pl_data;
    if (bus.mem_we)  mem_w[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem_w[bus.mem_addr[9:2]];
  end

  logic [7:0] ref_b [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    return {ref_b[base + 10'd3], ref_b[base + 10'd2], ref_b[base + 10'd1], ref_b[base]};
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [9:0] ba;
    for (int i = 0; i < nbytes(sz); i++) begin
      ba = a[9:0] + 10'(i);
      ref_b[ba] = d[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = w;
    ref_store({a[31:2], 2'b00}, w, 2'b10);
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    chk("ready_before", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_size = sz;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!legal(a, sz)) begin
      chk("err_pulse", 32'(bus.err), 1);
      chk("err_no_strobe", 32'({bus.mem_rd_en, bus.mem_we}), 0);
      chk("err_ready", 32'(bus.req_ready), 1);
      @(negedge clk);
      chk("err_clear", 32'(bus.err), 0);
      chk("err_no_strobe2", 32'({bus.mem_rd_en, bus.mem_we}), 0);
    end else if (sz == 2'b10) begin
      ref_store(a, d, sz);
      chk("sw_we", 32'({bus.mem_we, bus.done, bus.mem_rd_en}), 32'b110);
      chk("sw_ready_low", 32'(bus.req_ready), 0);
      chk("sw_addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("sw_wdata", bus.mem_wdata, d);
      @(negedge clk);
      chk("sw_ready_back", 32'(bus.req_ready), 1);
      chk("sw_idle_out", 32'({bus.mem_we, bus.done}), 0);
      chk("sw_mem", mem_w[a[9:2]], ref_word(a));
    end else begin
      chk("rmw_rd", 32'({bus.mem_rd_en, bus.mem_we, bus.req_ready}), 32'b100);
      chk("rmw_rd_addr", bus.mem_addr, {a[31:2], 2'b00});
      @(negedge clk);
      ref_store(a, d, sz);
      chk("rmw_wr", 32'({bus.mem_we, bus.done, bus.mem_rd_en}), 32'b110);
      chk("rmw_wr_addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("rmw_wdata", bus.mem_wdata, ref_word(a));
      @(negedge clk);
      chk("rmw_ready_back", 32'(bus.req_ready), 1);
      chk("rmw_mem", mem_w[a[9:2]], ref_word(a));
    end
  endtask

  typedef struct { logic [31:0] a; logic [31:0] d; logic [1:0] sz; } req_t;

  initial begin
    req_t stream [3];
    int   busy;
    logic [31:0] a;
    logic [1:0]  sz;

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_size = 2'b00;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst = 1'b1;

    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_strobes", 32'({bus.mem_rd_en, bus.mem_we, bus.done, bus.err}), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    // SB lane replace and SH halves on a known word
    preload(32'h100, 32'h11223344);
    send(32'h102, 32'h000000AB, 2'b00);
    chk("sb_lane2", mem_w[8'h40], 32'h11AB3344);
    preload(32'h100, 32'h11223344);
    send(32'h102, 32'h0000BEEF, 2'b01);
    chk("sh_upper", mem_w[8'h40], 32'hBEEF3344);
    preload(32'h100, 32'h11223344);
    send(32'h100, 32'h0000BEEF, 2'b01);
    chk("sh_lower", mem_w[8'h40], 32'h1122BEEF);
    send(32'h104, 32'hDEADBEEF, 2'b10);
    chk("sw_direct", mem_w[8'h41], 32'hDEADBEEF);

    // Misaligned / illegal requests accepted back to back
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h101; bus.req_size = 2'b01; bus.req_data = 32'h1;
    @(negedge clk);
    chk("err_sh101", 32'({bus.err, bus.req_ready, bus.mem_rd_en, bus.mem_we}), 32'b1100);
    bus.req_addr = 32'h106; bus.req_size = 2'b10;
    @(negedge clk);
    chk("err_sw106", 32'({bus.err, bus.req_ready, bus.mem_rd_en, bus.mem_we}), 32'b1100);
    bus.req_addr = 32'h100; bus.req_size = 2'b11;
    @(negedge clk);
    chk("err_size11", 32'({bus.err, bus.req_ready, bus.mem_rd_en, bus.mem_we}), 32'b1100);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("err_done", 32'({bus.err, bus.mem_rd_en, bus.mem_we}), 0);
    chk("err_mem_kept", mem_w[8'h40], ref_word(32'h100));

    // Reset during the WR cycle of an SB abandons the write
    preload(32'h100, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h102; bus.req_data = 32'hAB; bus.req_size = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstwr_rd", 32'(bus.mem_rd_en), 1);
    @(negedge clk);
    chk("rstwr_we_pre", 32'(bus.mem_we), 1);
    rst = 1'b1;
    #1;
    chk("rstwr_gated", 32'({bus.mem_we, bus.done, bus.mem_rd_en}), 0);
    chk("rstwr_addr0", bus.mem_addr, 0);
    chk("rstwr_wdata0", bus.mem_wdata, 0);
    @(negedge clk);
    chk("rstwr_ready", 32'(bus.req_ready), 1);
    chk("rstwr_mem", mem_w[8'h40], 32'h11223344);
    rst = 1'b0;
    send(32'h103, 32'h5A, 2'b00);
    chk("rstwr_next", mem_w[8'h40], 32'h5A223344);

    // Mixed stream with req_valid held high; junk presented while busy
    stream[0] = '{32'h109, 32'h77, 2'b00};
    stream[1] = '{32'h10C, 32'hCAFEF00D, 2'b10};
    stream[2] = '{32'h10A, 32'h1234, 2'b01};
    @(negedge clk);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stream_ready", 32'(bus.req_ready), 1);
      bus.req_addr = stream[i].a; bus.req_data = stream[i].d; bus.req_size = stream[i].sz;
      ref_store(stream[i].a, stream[i].d, stream[i].sz);
      busy = 0;
      @(negedge clk);
      bus.req_addr = 32'h3FC; bus.req_data = $urandom; bus.req_size = 2'b10;
      while (!bus.req_ready && busy < 10) begin
        busy++;
        @(negedge clk);
      end
      chk("stream_busy", 32'(busy), (stream[i].sz == 2'b10) ? 1 : 2);
    end
    bus.req_valid = 1'b0;
    chk("stream_w42", mem_w[8'h42], ref_word(32'h108));
    chk("stream_w43", mem_w[8'h43], ref_word(32'h10C));
    chk("stream_w3fc", mem_w[8'hFF], ref_word(32'h3FC));

    // Random stores, including misaligned and illegal ones
    for (int i = 0; i < 60; i++) begin
      a  = 32'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'b01) ? {a[1], 1'b0} : (sz == 2'b10) ? 2'b00 : a[1:0];
      send(a, $urandom, sz);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) chk("final_mem", mem_w[i], ref_word(32'(i * 4)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
